// File: rtl/uart_io_pkg.sv
// Shared definitions for uart_io: register offsets, STATUS bit positions and
// the 2-bit state encoding used by both the TX and RX state machines.
package uart_io_pkg;

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_LEVEL  = 2'd2;
    localparam logic [1:0] OFF_CTRL   = 2'd3;

    localparam int ST_TX_FULL    = 0;
    localparam int ST_TX_EMPTY   = 1;
    localparam int ST_RX_AVAIL   = 2;
    localparam int ST_RX_OVERRUN = 3;
    localparam int ST_FRAME_ERR  = 4;
    localparam int ST_TX_DROP    = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with a combinational head; DEPTH must be a power of 2 (>= 2).
// Push on full is ignored unless a pop happens in the same cycle.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/uart_io.sv
// Memory-mapped 8N1 UART with TX/RX FIFOs. Optional CTRL register and
// interrupt output are built only when UART_IO_IRQ_EN is defined.
module uart_io
    import uart_io_pkg::*;
#(
    parameter logic [15:0] BASE     = 16'h1004,
    parameter int          CLK_DIV  = 104,
    parameter int          TX_DEPTH = 8,
    parameter int          RX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] io_addr,
    input  logic [7:0]  io_wdata,
    input  logic        io_we,
    input  logic        io_re,
    output logic [7:0]  io_rdata,
    output logic        tx,
    input  logic        rx,
    output logic        irq
);

    localparam int CW = $clog2(CLK_DIV) + 1;
    localparam logic [CW-1:0] BIT_RELOAD  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_RELOAD = CW'(CLK_DIV / 2 - 1);

    logic       sel, wr, rd;
    logic [1:0] off;
    logic [7:0] status, rd_val, ctrl_rd;

    logic                       tx_push, tx_pop, tx_ff_full, tx_ff_empty;
    logic [7:0]                 tx_dout;
    logic [$clog2(TX_DEPTH):0]  tx_count;
    logic                       rx_pop, rx_full, rx_empty;
    logic [7:0]                 rx_dout;
    logic [$clog2(RX_DEPTH):0]  rx_count;

    logic rx_overrun, frame_err, tx_drop;

    assign sel = (io_addr[15:2] == BASE[15:2]);
    assign off = io_addr[1:0];
    assign wr  = io_we && sel;
    assign rd  = io_re && sel;

    assign tx_push = wr && (off == OFF_DATA) && !tx_ff_full;
    assign rx_pop  = rd && (off == OFF_DATA) && !rx_empty;

    uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(io_wdata),
        .dout(tx_dout), .full(tx_ff_full), .empty(tx_ff_empty), .count(tx_count)
    );

    // ---------------- TX state machine ----------------
    uart_state_t   tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_sh;
    logic          tx_idle_empty;

    // Stop bit end reloads straight into START so consecutive bytes have no gap.
    assign tx_pop = !tx_ff_empty && (tx_state == IDLE || (tx_state == STOP && tx_cnt == '0));
    assign tx_idle_empty = tx_ff_empty && (tx_state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx       <= 1'b1;
        end else begin
            case (tx_state)
                IDLE: if (tx_pop) begin
                    tx_state <= START;
                    tx       <= 1'b0;
                    tx_cnt   <= BIT_RELOAD;
                end
                START: if (tx_cnt == '0) begin
                    tx_state <= DATA;
                    tx       <= tx_sh[0];
                    tx_cnt   <= BIT_RELOAD;
                    tx_bit   <= '0;
                end else tx_cnt <= tx_cnt - 1'b1;
                DATA: if (tx_cnt == '0) begin
                    tx_cnt <= BIT_RELOAD;
                    if (tx_bit == 3'd7) begin
                        tx_state <= STOP;
                        tx       <= 1'b1;
                    end else begin
                        tx     <= tx_sh[1];
                        tx_bit <= tx_bit + 1'b1;
                    end
                end else tx_cnt <= tx_cnt - 1'b1;
                STOP: if (tx_cnt == '0) begin
                    if (tx_pop) begin
                        tx_state <= START;
                        tx       <= 1'b0;
                        tx_cnt   <= BIT_RELOAD;
                    end else tx_state <= IDLE;
                end else tx_cnt <= tx_cnt - 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (tx_pop) tx_sh <= tx_dout;
        else if (tx_state == DATA && tx_cnt == '0) tx_sh <= tx_sh >> 1;
    end

    // ---------------- RX synchronizer and state machine ----------------
    logic          rx_m, rx_s, rx_q;
    uart_state_t   rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_sh;
    logic          rx_brk, rx_done, rx_ferr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) {rx_m, rx_s, rx_q} <= 3'b111;
        else     {rx_m, rx_s, rx_q} <= {rx, rx_m, rx_s};
    end

    // rx_brk blocks start detection after a framing error until the line idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_brk   <= 1'b0;
            rx_done  <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            rx_ferr <= 1'b0;
            case (rx_state)
                IDLE: if (rx_brk) begin
                    if (rx_s) rx_brk <= 1'b0;
                end else if (rx_q && !rx_s) begin
                    rx_state <= START;
                    rx_cnt   <= HALF_RELOAD;
                end
                START: if (rx_cnt == '0) begin
                    rx_state <= rx_s ? IDLE : DATA;
                    rx_cnt   <= BIT_RELOAD;
                    rx_bit   <= '0;
                end else rx_cnt <= rx_cnt - 1'b1;
                DATA: if (rx_cnt == '0) begin
                    rx_cnt <= BIT_RELOAD;
                    if (rx_bit == 3'd7) rx_state <= STOP;
                    else                rx_bit   <= rx_bit + 1'b1;
                end else rx_cnt <= rx_cnt - 1'b1;
                STOP: if (rx_cnt == '0) begin
                    rx_state <= IDLE;
                    rx_done  <= rx_s;
                    rx_ferr  <= !rx_s;
                    rx_brk   <= !rx_s;
                end else rx_cnt <= rx_cnt - 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rx_state == DATA && rx_cnt == '0) rx_sh <= {rx_s, rx_sh[7:1]};
    end

    uart_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_done), .pop(rx_pop), .din(rx_sh),
        .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    // ---------------- Sticky flags, read mux, CTRL/irq ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
            tx_drop    <= 1'b0;
        end else begin
            if (rd && off == OFF_STATUS) begin
                rx_overrun <= 1'b0;
                frame_err  <= 1'b0;
                tx_drop    <= 1'b0;
            end
            if (rx_done && rx_full && !rx_pop)             rx_overrun <= 1'b1;
            if (rx_ferr)                                   frame_err  <= 1'b1;
            if (wr && off == OFF_DATA && tx_ff_full)       tx_drop    <= 1'b1;
        end
    end

    assign status = {2'b00, tx_drop, frame_err, rx_overrun, !rx_empty, tx_idle_empty, tx_ff_full};

    always_comb begin
        rd_val = 8'h00;
        case (off)
            OFF_DATA:   rd_val = rx_empty ? 8'h00 : rx_dout;
            OFF_STATUS: rd_val = status;
            OFF_LEVEL:  rd_val = {4'(tx_count), 4'(rx_count)};
            OFF_CTRL:   rd_val = ctrl_rd;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     io_rdata <= 8'h00;
        else if (rd) io_rdata <= rd_val;
    end

`ifdef UART_IO_IRQ_EN
    logic [2:0] ctrl;

    assign ctrl_rd = {5'b00000, ctrl};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl <= 3'b000;
            irq  <= 1'b0;
        end else begin
            if (wr && off == OFF_CTRL) ctrl <= io_wdata[2:0];
            irq <= (ctrl[0] && !rx_empty) || (ctrl[1] && tx_idle_empty) ||
                   (ctrl[2] && (rx_overrun || frame_err || tx_drop));
        end
    end
`else
    assign ctrl_rd = 8'h00;
    assign irq     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_io.sv
// Self-checking bench for uart_io at CLK_DIV=8; define UART_IO_IRQ_EN to
// exercise the CTRL/irq path, otherwise its absence is checked.
module tb_uart_io;

    localparam int DIV = 8;
    localparam logic [15:0] A_DATA   = 16'h1004;
    localparam logic [15:0] A_STATUS = 16'h1005;
    localparam logic [15:0] A_LEVEL  = 16'h1006;
    localparam logic [15:0] A_CTRL   = 16'h1007;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] io_addr;
    logic [7:0]  io_wdata;
    logic        io_we, io_re;
    logic [7:0]  io_rdata;
    logic        tx;
    logic        rx;
    logic        irq;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] tx_q [$];
    logic [7:0] rx_q [$];

    uart_io #(.BASE(16'h1004), .CLK_DIV(DIV), .TX_DEPTH(8), .RX_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_we(io_we), .io_re(io_re), .io_rdata(io_rdata),
        .tx(tx), .rx(rx), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        io_addr = a; io_wdata = d; io_we = 1'b1;
        @(posedge clk); #1;
        io_we = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
        io_addr = a; io_re = 1'b1;
        @(posedge clk); #1;
        d = io_rdata;
        io_re = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        rx = 1'b0; cyc(DIV);
        for (int k = 0; k < 8; k++) begin rx = b[k]; cyc(DIV); end
        rx = stop; cyc(DIV);
        rx = 1'b1; cyc(DIV);
    endtask

    task automatic wait_tx_idle(input string tag);
        logic [7:0] d;
        bit done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            bus_read(A_STATUS, d);
            if (d[1]) done = 1;
        end
        chk(tag, 16'(done), 16'd1);
    endtask

    // Independent line decoder: samples each bit at its midpoint, discards frames cut by reset.
    initial begin : tx_mon
        logic [7:0] b;
        logic st, sp;
        bit ab;
        forever begin
            @(negedge tx);
            ab = 0;
            for (int i = 0; i < DIV/2; i++) begin @(posedge clk); #1; if (rst) ab = 1; end
            st = tx;
            for (int k = 0; k < 8; k++) begin
                for (int i = 0; i < DIV; i++) begin @(posedge clk); #1; if (rst) ab = 1; end
                b[k] = tx;
            end
            for (int i = 0; i < DIV; i++) begin @(posedge clk); #1; if (rst) ab = 1; end
            sp = tx;
            if (!ab) begin
                chk("tx_start_bit", 16'(st), 16'd0);
                chk("tx_stop_bit", 16'(sp), 16'd1);
                if (tx_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL tx_unexpected_frame: got %h expected none", b);
                end else begin
                    chk("tx_byte", 16'(b), 16'(tx_q.pop_front()));
                end
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [7:0] d;
        int w;
        bit seen;
        rst = 1'b1; io_addr = 16'h0000; io_wdata = 8'h00; io_we = 1'b0; io_re = 1'b0; rx = 1'b1;
        cyc(3);
        chk("reset_tx", 16'(tx), 16'd1);
        chk("reset_rdata", 16'(io_rdata), 16'h00);
        chk("reset_irq", 16'(irq), 16'd0);
        rst = 1'b0;
        cyc(2);

        // Out-of-window access does nothing and io_rdata holds
        bus_write(16'h1008, 8'h99);
        bus_read(16'h1000, d);
        chk("unselected_read", 16'(d), 16'h00);
        bus_read(A_LEVEL, d);
        chk("unselected_write", 16'(d), 16'h00);

        // T1 single TX frame
        tx_q.push_back(8'hA5);
        bus_write(A_DATA, 8'hA5);
        seen = 0;
        for (int i = 0; i < 2 && !seen; i++) begin @(posedge clk); #1; if (tx == 1'b0) seen = 1; end
        chk("t1_start_latency", 16'(seen), 16'd1);
        w = 1;
        for (int i = 0; i < 20 && tx == 1'b0; i++) begin @(posedge clk); #1; if (tx == 1'b0) w++; end
        chk("t1_start_width", 16'(w), 16'(DIV));
        wait_tx_idle("t1_drain");
        bus_read(A_STATUS, d);
        chk("t1_status", 16'(d), 16'h02);

        // T2 TX overflow
        for (int i = 0; i < 9; i++) begin
            tx_q.push_back(8'(8'h10 + i));
            bus_write(A_DATA, 8'(8'h10 + i));
        end
        bus_read(A_LEVEL, d);
        chk("t2_level", 16'(d), 16'h80);
        bus_write(A_DATA, 8'hEE);
        bus_read(A_STATUS, d);
        chk("t2_status_drop", 16'(d), 16'h21);
        bus_read(A_STATUS, d);
        chk("t2_status_cleared", 16'(d), 16'h01);
        wait_tx_idle("t2_drain");

        // T3 RX good frame, then framing error
        bus_read(A_DATA, d);
        chk("t3_empty_data", 16'(d), 16'h00);
        rx_q.push_back(8'h3C);
        send_rx(8'h3C, 1'b1);
        bus_read(A_STATUS, d);
        chk("t3_rx_avail", 16'(d), 16'h06);
        bus_read(A_DATA, d);
        chk("t3_rx_data", 16'(d), 16'(rx_q.pop_front()));
        bus_read(A_STATUS, d);
        chk("t3_rx_drained", 16'(d), 16'h02);
        send_rx(8'h3C, 1'b0);
        bus_read(A_LEVEL, d);
        chk("t3_ferr_level", 16'(d), 16'h00);
        bus_read(A_STATUS, d);
        chk("t3_ferr_status", 16'(d), 16'h12);
        bus_read(A_STATUS, d);
        chk("t3_ferr_cleared", 16'(d), 16'h02);

        // T4 RX overrun
        for (int i = 0; i < 5; i++) begin
            if (i < 4) rx_q.push_back(8'(8'h11 * (i + 1)));
            send_rx(8'(8'h11 * (i + 1)), 1'b1);
        end
        bus_read(A_LEVEL, d);
        chk("t4_level", 16'(d), 16'h04);
        bus_read(A_STATUS, d);
        chk("t4_status", 16'(d), 16'h0E);
        for (int i = 0; i < 4; i++) begin
            bus_read(A_DATA, d);
            chk("t4_rx_data", 16'(d), 16'(rx_q.pop_front()));
        end
        bus_read(A_STATUS, d);
        chk("t4_status_after", 16'(d), 16'h02);

        // T5 glitch rejection, then reset mid-frame
        rx = 1'b0; cyc(2); rx = 1'b1; cyc(100);
        bus_read(A_LEVEL, d);
        chk("t5_glitch_level", 16'(d), 16'h00);
        bus_read(A_STATUS, d);
        chk("t5_glitch_status", 16'(d), 16'h02);
        send_rx(8'h5A, 1'b1);
        bus_write(A_DATA, 8'hC3);
        bus_write(A_DATA, 8'h3C);
        cyc(1 + 4*DIV + 2);
        chk("t5_tx_low_in_bit3", 16'(tx), 16'd0);
        rst = 1'b1;
        #1;
        chk("t5_tx_async_high", 16'(tx), 16'd1);
        cyc(2);
        rst = 1'b0;
        cyc(2);
        bus_read(A_LEVEL, d);
        chk("t5_level_after_rst", 16'(d), 16'h00);
        bus_read(A_STATUS, d);
        chk("t5_status_after_rst", 16'(d), 16'h02);
        bus_read(A_DATA, d);
        chk("t5_data_after_rst", 16'(d), 16'h00);
        cyc(10*DIV);
        chk("t5_tx_idle", 16'(tx), 16'd1);

        // T6 CTRL and irq
`ifdef UART_IO_IRQ_EN
        bus_write(A_CTRL, 8'h01);
        bus_read(A_CTRL, d);
        chk("t6_ctrl_read", 16'(d), 16'h01);
        chk("t6_irq_idle", 16'(irq), 16'd0);
        rx_q.push_back(8'h77);
        send_rx(8'h77, 1'b1);
        chk("t6_irq_high", 16'(irq), 16'd1);
        bus_read(A_DATA, d);
        chk("t6_rx_data", 16'(d), 16'(rx_q.pop_front()));
        chk("t6_irq_lag", 16'(irq), 16'd1);
        cyc(1);
        chk("t6_irq_low", 16'(irq), 16'd0);
        bus_write(A_CTRL, 8'h00);
`else
        bus_write(A_CTRL, 8'hFF);
        bus_read(A_CTRL, d);
        chk("t6_ctrl_absent", 16'(d), 16'h00);
        rx_q.push_back(8'h77);
        send_rx(8'h77, 1'b1);
        chk("t6_irq_tied", 16'(irq), 16'd0);
        bus_read(A_DATA, d);
        chk("t6_rx_data", 16'(d), 16'(rx_q.pop_front()));
        chk("t6_irq_tied_after", 16'(irq), 16'd0);
`endif

        cyc(20);
        chk("tx_scoreboard_empty", 16'(tx_q.size()), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
